// File: rtl/turnstile_pkg.sv
// Shared definitions for the turnstile fare controller: FSM states,
// coin denomination encoding and gate-state constants.
package turnstile_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_COLLECT     = 3'd1,
      ST_VEND        = 3'd2,
      ST_WAIT_UNLOCK = 3'd3,
      ST_WAIT_PASS   = 3'd4,
      ST_REFUND      = 3'd5,
      ST_FAULT       = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      DENOM_1   = 2'b00,
      DENOM_2   = 2'b01,
      DENOM_5   = 2'b10,
      DENOM_BAD = 2'b11
   } denom_t;

   localparam logic LOCKED   = 1'b0;
   localparam logic UNLOCKED = 1'b1;

   // Credit units carried by a coin; the invalid code carries nothing.
   function automatic logic [2:0] coin_units(input logic [1:0] code);
      logic [2:0] units;
      case (code)
         DENOM_1: units = 3'd1;
         DENOM_2: units = 3'd2;
         DENOM_5: units = 3'd5;
         default: units = 3'd0;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/turnstile_fare_ctrl.sv
// Coin-operated turnstile controller: accumulates credit, vends one passage
// with change, refunds on cancel and latches a fault if the gate never unlocks.
module turnstile_fare_ctrl
   import turnstile_pkg::*;
#(
   parameter int FARE      = 4,
   parameter int CREDIT_W  = 4,
   parameter int UNLOCK_TO = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                coin_valid,
   input  logic [1:0]          coin_value,
   input  logic                cancel,
   input  logic                gate_state,
   output logic                coin,
   output logic                coin_ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_value,
   output logic                reject,
   output logic                fault
);

   localparam int TO_W  = $clog2(UNLOCK_TO + 1);
   localparam int SUM_W = CREDIT_W + 3;
   localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
   localparam logic [SUM_W-1:0] FARE_S     = SUM_W'(FARE);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(UNLOCK_TO - 1);

   state_t            state;
   logic [TO_W-1:0]   to_cnt;
   logic [SUM_W-1:0]  sum;
   logic              coin_ok;

   // Sum is computed wide so an overflowing coin can be detected and refused.
   always_comb begin
      sum     = {3'b000, credit} + SUM_W'(coin_units(coin_value));
      coin_ok = (coin_value != DENOM_BAD) && (sum <= CREDIT_MAX);
   end

   assign coin_ready = (state == ST_IDLE) || (state == ST_COLLECT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         credit       <= '0;
         to_cnt       <= '0;
         coin         <= 1'b0;
         change_valid <= 1'b0;
         change_value <= '0;
         reject       <= 1'b0;
         fault        <= 1'b0;
      end else begin
         coin         <= 1'b0;
         change_valid <= 1'b0;
         change_value <= '0;
         reject       <= 1'b0;
         case (state)
            ST_IDLE, ST_COLLECT: begin
               if (state == ST_COLLECT && cancel) begin
                  state        <= ST_REFUND;
                  change_valid <= 1'b1;
                  change_value <= credit;
                  credit       <= '0;
                  reject       <= coin_valid;
               end else if (coin_valid) begin
                  if (!coin_ok) begin
                     reject <= 1'b1;
                  end else if (sum >= FARE_S) begin
                     state        <= ST_VEND;
                     coin         <= 1'b1;
                     change_valid <= 1'b1;
                     change_value <= CREDIT_W'(sum - FARE_S);
                     credit       <= '0;
                  end else begin
                     state  <= ST_COLLECT;
                     credit <= CREDIT_W'(sum);
                  end
               end
            end
            ST_VEND: begin
               reject <= coin_valid;
               to_cnt <= '0;
               state  <= ST_WAIT_UNLOCK;
            end
            ST_WAIT_UNLOCK: begin
               reject <= coin_valid;
               if (gate_state == UNLOCKED) begin
                  to_cnt <= '0;
                  state  <= ST_WAIT_PASS;
               end else if (to_cnt == TO_LAST) begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_WAIT_PASS: begin
               reject <= coin_valid;
               if (gate_state == LOCKED) state <= ST_IDLE;
            end
            ST_REFUND: begin
               reject <= coin_valid;
               state  <= ST_IDLE;
            end
            ST_FAULT: begin
               reject <= coin_valid;
               fault  <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_turnstile_fare_ctrl.sv
// Directed bench for turnstile_fare_ctrl: table of single-cycle vectors plus
// hand sequences for timeout, overflow and asynchronous reset.
module tb_turnstile_fare_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_value = 2'b00;
   logic       cancel = 1'b0;
   logic       gate_state = 1'b0;
   logic       coin, coin_ready, change_valid, reject, fault;
   logic [3:0] credit, change_value;

   // Second instance with a high fare so the credit ceiling can be reached.
   logic       c2_valid = 1'b0;
   logic [1:0] c2_value = 2'b00;
   logic       c2_cancel = 1'b0;
   logic       c2_gate = 1'b0;
   logic       c2_coin, c2_ready, c2_cv, c2_reject, c2_fault;
   logic [3:0] c2_credit, c2_chg;

   int n_checks = 0;
   int n_pass   = 0;

   turnstile_fare_ctrl #(.FARE(4), .CREDIT_W(4), .UNLOCK_TO(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_value(coin_value),
      .cancel(cancel), .gate_state(gate_state), .coin(coin), .coin_ready(coin_ready),
      .credit(credit), .change_valid(change_valid), .change_value(change_value),
      .reject(reject), .fault(fault));

   turnstile_fare_ctrl #(.FARE(15), .CREDIT_W(4), .UNLOCK_TO(8)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .coin_valid(c2_valid), .coin_value(c2_value),
      .cancel(c2_cancel), .gate_state(c2_gate), .coin(c2_coin), .coin_ready(c2_ready),
      .credit(c2_credit), .change_valid(c2_cv), .change_value(c2_chg),
      .reject(c2_reject), .fault(c2_fault));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       cv_in;
      logic [1:0] val_in;
      logic       cancel_in;
      logic       gate_in;
      logic [12:0] exp;   // {coin, ready, credit[3:0], change_valid, change_value[3:0], reject, fault}
   } vec_t;

   vec_t vecs[20];

   function automatic vec_t mkv(input logic v, input logic [1:0] val, input logic c,
                                input logic g, input logic e_coin, input logic e_rdy,
                                input logic [3:0] e_cred, input logic e_cv,
                                input logic [3:0] e_chg, input logic e_rej);
      vec_t r;
      r.cv_in = v; r.val_in = val; r.cancel_in = c; r.gate_in = g;
      r.exp = {e_coin, e_rdy, e_cred, e_cv, e_chg, e_rej, 1'b0};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic idle_inputs();
      coin_valid = 1'b0; coin_value = 2'b00; cancel = 1'b0;
   endtask

   task automatic coin2(input logic [1:0] val);
      c2_valid = 1'b1; c2_value = val;
      tick();
      c2_valid = 1'b0;
   endtask

   initial begin
      //                v  val    c  g  coin rdy cred cv chg rej
      vecs[0]  = mkv(1, 2'b01, 0, 0, 0, 1, 4'd2, 0, 4'd0, 0); // coin 2
      vecs[1]  = mkv(1, 2'b01, 0, 0, 1, 0, 4'd0, 1, 4'd0, 0); // coin 2 -> vend, exact fare
      vecs[2]  = mkv(0, 2'b00, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0); // wait unlock
      vecs[3]  = mkv(0, 2'b00, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0); // gate unlocked
      vecs[4]  = mkv(0, 2'b00, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
      vecs[5]  = mkv(1, 2'b10, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1); // coin during wait_pass
      vecs[6]  = mkv(0, 2'b00, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0); // passage done -> idle
      vecs[7]  = mkv(1, 2'b10, 0, 0, 1, 0, 4'd0, 1, 4'd1, 0); // coin 5 -> change 1
      vecs[8]  = mkv(0, 2'b00, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0);
      vecs[9]  = mkv(0, 2'b00, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
      vecs[10] = mkv(0, 2'b00, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
      vecs[11] = mkv(1, 2'b11, 0, 0, 0, 1, 4'd0, 0, 4'd0, 1); // invalid coin code
      vecs[12] = mkv(1, 2'b00, 0, 0, 0, 1, 4'd1, 0, 4'd0, 0); // coin 1
      vecs[13] = mkv(1, 2'b01, 1, 0, 0, 0, 4'd0, 1, 4'd1, 1); // cancel beats coin
      vecs[14] = mkv(0, 2'b00, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
      vecs[15] = mkv(0, 2'b00, 1, 0, 0, 1, 4'd0, 0, 4'd0, 0); // cancel in idle ignored
      vecs[16] = mkv(1, 2'b00, 0, 0, 0, 1, 4'd1, 0, 4'd0, 0);
      vecs[17] = mkv(1, 2'b00, 0, 0, 0, 1, 4'd2, 0, 4'd0, 0);
      vecs[18] = mkv(0, 2'b00, 1, 0, 0, 0, 4'd0, 1, 4'd2, 0); // refund 2
      vecs[19] = mkv(0, 2'b00, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);

      // Reset state while reset_n is low.
      #12;
      check("rst_credit", 32'(credit), 32'd0);
      check("rst_pulses", 32'({coin, change_valid, reject, fault}), 32'd0);
      check("rst_chg", 32'(change_value), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_ready", 32'(coin_ready), 32'd1);

      foreach (vecs[i]) begin
         coin_valid = vecs[i].cv_in; coin_value = vecs[i].val_in;
         cancel = vecs[i].cancel_in; gate_state = vecs[i].gate_in;
         tick();
         check($sformatf("vec%0d", i),
               32'({coin, coin_ready, credit, change_valid, change_value, reject, fault}),
               32'(vecs[i].exp));
      end
      idle_inputs();
      gate_state = 1'b0;

      // Credit ceiling on the high-fare instance: 15 is the maximum credit.
      coin2(2'b10); coin2(2'b10); coin2(2'b01);
      check("ovf_pre_credit", 32'(c2_credit), 32'd12);
      coin2(2'b10);
      check("ovf_reject", 32'({c2_reject, c2_credit}), 32'h1C);
      coin2(2'b01);
      check("ovf_credit14", 32'(c2_credit), 32'd14);
      coin2(2'b00);
      check("max_vend", 32'({c2_coin, c2_cv, c2_chg, c2_credit}), 32'h300);

      // Gate never unlocks: fault after eight cycles in WAIT_UNLOCK.
      coin_valid = 1'b1; coin_value = 2'b10;
      tick();
      idle_inputs();
      check("to_vend", 32'({coin, change_value}), 32'h11);
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("to_not_yet", 32'({fault, coin_ready}), 32'd0);
      tick();
      check("to_fault", 32'({fault, coin_ready, coin}), 32'h4);
      coin_valid = 1'b1; coin_value = 2'b00;
      tick();
      idle_inputs();
      check("fault_reject", 32'({reject, fault, coin_ready}), 32'h6);
      tick();
      check("fault_sticky", 32'({reject, fault}), 32'h1);
      #3 reset_n = 1'b0;
      #1 check("fault_async_clr", 32'(fault), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      check("fault_rst_idle", 32'({coin_ready, fault, credit}), 32'h20);

      // Asynchronous reset with credit held: no change pulse.
      coin_valid = 1'b1; coin_value = 2'b00;
      tick();
      coin_value = 2'b01;
      tick();
      idle_inputs();
      check("mid_credit3", 32'(credit), 32'd3);
      #3 reset_n = 1'b0;
      #1 check("mid_async_credit", 32'({credit, change_valid}), 32'd0);
      tick();
      check("mid_no_change", 32'({change_valid, change_value}), 32'd0);
      reset_n = 1'b1;
      tick();
      check("mid_after", 32'({coin_ready, credit, change_valid}), 32'h20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/turnstile_fare_ctrl.md
TURNSTILE_FARE_CTRL -- requirements
Module: turnstile_fare_ctrl

Interface
REQ-001 SHALL have parameter FARE, default 4, credit units needed for one passage (1..2^CREDIT_W-1).
REQ-002 SHALL have parameter CREDIT_W, default 4, width of credit and change values.
REQ-003 SHALL have parameter UNLOCK_TO, default 8, cycles allowed for the gate to report unlocked after a coin pulse.
REQ-004 SHALL have ports:
  clk  input  1  rising-edge clock
  reset_n  input  1  asynchronous active-low reset
  coin_valid  input  1  one-cycle strobe: coin inserted
  coin_value  input  2  denomination: 00=1, 01=2, 10=5, 11=invalid
  cancel  input  1  user refund request
  gate_state  input  1  turnstile state: 0=LOCKED, 1=UNLOCKED
  coin  output  1  one-cycle unlock pulse to turnstile
  coin_ready  output  1  block accepts coins this cycle
  credit  output  CREDIT_W  current accumulated credit
  change_valid  output  1  one-cycle strobe: change_value is valid
  change_value  output  CREDIT_W  credit units to return
  reject  output  1  one-cycle strobe: offered coin refused
  fault  output  1  gate failed to unlock; sticky

Function
REQ-005 SHALL implement states IDLE, COLLECT, VEND, WAIT_UNLOCK, WAIT_PASS, REFUND, FAULT.
REQ-006 coin_ready SHALL be 1 exactly in IDLE and COLLECT.
REQ-007 In IDLE/COLLECT, valid coin with credit+value <= 2^CREDIT_W-1 SHALL add value to credit on the next edge; state becomes COLLECT.
REQ-008 Coin causing overflow, coin_value=11, or any coin_valid while coin_ready=0 SHALL leave credit unchanged and pulse reject the next cycle.
REQ-009 When updated credit >= FARE, next state SHALL be VEND.
REQ-010 VEND (one cycle) SHALL assert coin=1, change_valid=1, change_value=credit-FARE (0 allowed), clear credit; next state WAIT_UNLOCK.
REQ-011 WAIT_UNLOCK SHALL go to WAIT_PASS on gate_state=1; if gate_state stays 0 for UNLOCK_TO cycles, SHALL go to FAULT.
REQ-012 WAIT_PASS SHALL go to IDLE when gate_state returns to 0 (passage completed); no timeout.
REQ-013 cancel in COLLECT SHALL go to REFUND; REFUND (one cycle) SHALL pulse change_valid with change_value=credit, clear credit, then IDLE.
REQ-014 cancel in IDLE SHALL be ignored; cancel in any other state SHALL be ignored.
REQ-015 Simultaneous coin_valid and cancel in COLLECT: cancel wins, coin rejected (reject pulse), refund is credit before the coin.
REQ-016 FAULT SHALL hold fault=1, coin_ready=0, coin=0; exit only via reset.
REQ-017 coin, change_valid, reject SHALL be registered, never high more than one consecutive cycle per event.
REQ-018 change_value SHALL be 0 whenever change_valid=0.

Reset
REQ-019 reset_n=0 SHALL asynchronously force state IDLE, credit 0, timeout counter 0, all outputs 0 except coin_ready, which reads 1 once reset_n=1.
REQ-020 Reset mid-transaction SHALL discard credit without any change pulse.

Structure
REQ-021 Shared package turnstile_pkg SHALL hold the state enum, denomination encoding and constants LOCKED=0/UNLOCKED=1 used with the turnstile fsm.
REQ-022 No sub-module; the unlock-timeout counter SHALL be inline, width clog2(UNLOCK_TO+1).

Verification (FARE=4, CREDIT_W=4, UNLOCK_TO=8)
REQ-023 Coins 2,2; gate_state rises 1 cycle after coin, falls 3 later -> coin pulse once, change_value=0, back to IDLE, credit=0.
REQ-024 Coin 5 -> VEND: coin=1, change_valid=1, change_value=1; credit=0.
REQ-025 Coin 1, then cancel with coin_valid (value 2) same cycle -> reject pulse, REFUND change_value=1, IDLE.
REQ-026 Coin during WAIT_PASS -> reject=1, credit unchanged 0; coin_value=11 in IDLE -> reject=1.
REQ-027 Coin 5, gate_state held 0 -> fault=1 after 8 cycles in WAIT_UNLOCK, coin_ready=0; reset_n pulse -> IDLE, fault=0.
REQ-028 Credit 3 then reset_n=0 asynchronously mid-cycle -> credit=0 immediately, no change_valid.
